// File: rtl/toaplan_snd_pkg.sv
// Shared constants for the 68000 <-> Z80 sound command mailbox.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package toaplan_snd_pkg;

    localparam logic [7:0] SND_STATUS_PORT = 8'h63;
    localparam logic [7:0] SND_LATCH_PORT  = 8'ha0;
    localparam logic [7:0] SND_DONE_PORT   = 8'hb0;

    localparam int ST_PENDING = 0;
    localparam int ST_OVERRUN = 1;

    typedef struct packed {
        logic cmd_wr;
        logic cmd_rd;
        logic st_rd;
        logic done_wr;
        logic reply_ack;
    } snd_strobe_t;

    function automatic logic [7:0] status_byte(input logic pending, input logic overrun);
        logic [7:0] s;
        s             = '0;
        s[ST_PENDING] = pending;
        s[ST_OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Single-flop edge detector for a qualified bus strobe.
// Latency: rise/fall are combinational against the previous sample.
// Backpressure: none; en masks events while the detector primes after reset.
module strobe_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = en & d & ~q;
    assign fall = en & ~d & q;

endmodule

// File: rtl/sound_mailbox.sv
// Byte command mailbox 68000 -> Z80 with pending/overrun status and a Z80 reply byte back.
// Latency: strobe edge sampled at clock N updates state at N, visible after N.
// Backpressure: none; a second command before the Z80 read overwrites and flags overrun.
module sound_mailbox
    import toaplan_snd_pkg::*;
#(
    parameter bit STATUS_PORT_OE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sound_latch_w_cs,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_dout,
    input  logic       sound_latch_r_cs,
    input  logic       sound_status_cs,
    input  logic       sound_done_cs,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic [7:0] z80_dout,
    output logic [7:0] z80_din,
    output logic       z80_din_oe,
    output logic       z80_int_n,
    output logic [7:0] m68k_reply,
    output logic       m68k_reply_valid,
    input  logic       m68k_reply_ack
);

    snd_strobe_t lvl, rise, fall;
    logic [7:0]  cmd;
    logic        pending, overrun;
    logic        primed;

    assign lvl.cmd_wr    = sound_latch_w_cs & ~cpu_rw;
    assign lvl.cmd_rd    = sound_latch_r_cs & ~z80_rd_n;
    assign lvl.st_rd     = sound_status_cs & ~z80_rd_n;
    assign lvl.done_wr   = sound_done_cs & ~z80_wr_n;
    assign lvl.reply_ack = m68k_reply_ack;

    // The first clock after reset only loads the edge flops, so a strobe
    // still asserted across reset release is never taken as a new access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end

    strobe_edge u_cmd_wr (.clk(clk), .reset_n(reset_n), .en(primed), .d(lvl.cmd_wr),
                          .rise(rise.cmd_wr), .fall(fall.cmd_wr));
    strobe_edge u_cmd_rd (.clk(clk), .reset_n(reset_n), .en(primed), .d(lvl.cmd_rd),
                          .rise(rise.cmd_rd), .fall(fall.cmd_rd));
    strobe_edge u_st_rd (.clk(clk), .reset_n(reset_n), .en(primed), .d(lvl.st_rd),
                         .rise(rise.st_rd), .fall(fall.st_rd));
    strobe_edge u_done_wr (.clk(clk), .reset_n(reset_n), .en(primed), .d(lvl.done_wr),
                           .rise(rise.done_wr), .fall(fall.done_wr));
    strobe_edge u_reply_ack (.clk(clk), .reset_n(reset_n), .en(primed), .d(lvl.reply_ack),
                             .rise(rise.reply_ack), .fall(fall.reply_ack));

    logic unused_edges;
    assign unused_edges = ^{rise.cmd_rd, rise.st_rd, fall.cmd_wr, fall.done_wr, fall.reply_ack};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd              <= 8'h00;
            pending          <= 1'b0;
            overrun          <= 1'b0;
            m68k_reply       <= 8'h00;
            m68k_reply_valid <= 1'b0;
        end else begin
            if (rise.cmd_wr) begin
                cmd <= cpu_dout;
            end

            // A write landing on the trailing edge of the Z80 read replaces a
            // command that was just consumed, so it is not an overrun.
            if (rise.cmd_wr) begin
                pending <= 1'b1;
            end else if (fall.cmd_rd) begin
                pending <= 1'b0;
            end

            if (rise.cmd_wr && pending && !fall.cmd_rd) begin
                overrun <= 1'b1;
            end else if (fall.st_rd) begin
                overrun <= 1'b0;
            end

            if (rise.done_wr) begin
                m68k_reply       <= z80_dout;
                m68k_reply_valid <= 1'b1;
            end else if (rise.reply_ack) begin
                m68k_reply_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        z80_din = 8'h00;
        if (lvl.cmd_rd) begin
            z80_din = cmd;
        end else if (lvl.st_rd) begin
            z80_din = status_byte(pending, overrun);
        end
    end

    assign z80_din_oe = lvl.cmd_rd | (lvl.st_rd & STATUS_PORT_OE);
    assign z80_int_n  = ~pending;

endmodule

// File: tb/tb_sound_mailbox.sv
// Directed test-plan sequences plus randomized bus traffic against a behavioural mailbox model.
module tb_sound_mailbox;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sound_latch_w_cs, cpu_rw, sound_latch_r_cs, sound_status_cs, sound_done_cs;
    logic       z80_rd_n, z80_wr_n, m68k_reply_ack;
    logic [7:0] cpu_dout, z80_dout;
    logic [7:0] z80_din, m68k_reply;
    logic       z80_din_oe, z80_int_n, m68k_reply_valid;

    always #5 clk = ~clk;

    sound_mailbox #(.STATUS_PORT_OE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .sound_latch_w_cs(sound_latch_w_cs), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout),
        .sound_latch_r_cs(sound_latch_r_cs), .sound_status_cs(sound_status_cs),
        .sound_done_cs(sound_done_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
        .z80_dout(z80_dout), .z80_din(z80_din), .z80_din_oe(z80_din_oe),
        .z80_int_n(z80_int_n), .m68k_reply(m68k_reply),
        .m68k_reply_valid(m68k_reply_valid), .m68k_reply_ack(m68k_reply_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: mailbox contents plus the last-seen level of each access.
    logic [7:0] m_cmd, m_reply;
    bit         m_pending, m_overrun, m_valid, m_seen_clock;
    bit         p_wr, p_rd, p_st, p_done, p_ack;

    function automatic bit a_wr();   return sound_latch_w_cs && !cpu_rw;   endfunction
    function automatic bit a_rd();   return sound_latch_r_cs && !z80_rd_n; endfunction
    function automatic bit a_st();   return sound_status_cs && !z80_rd_n;  endfunction
    function automatic bit a_done(); return sound_done_cs && !z80_wr_n;    endfunction

    task automatic model_reset();
        m_cmd = 8'h00; m_reply = 8'h00;
        m_pending = 0; m_overrun = 0; m_valid = 0; m_seen_clock = 0;
        {p_wr, p_rd, p_st, p_done, p_ack} = '0;
    endtask

    task automatic model_clock();
        bit wr, rd, st, dn, ak;
        wr = a_wr(); rd = a_rd(); st = a_st(); dn = a_done(); ak = m68k_reply_ack;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_seen_clock) begin
            bit wr_start, rd_end, st_end, dn_start, ak_start;
            wr_start = wr && !p_wr;
            rd_end   = !rd && p_rd;
            st_end   = !st && p_st;
            dn_start = dn && !p_done;
            ak_start = ak && !p_ack;
            if (st_end) m_overrun = 0;
            if (wr_start) begin
                if (m_pending && !rd_end) m_overrun = 1;
                m_cmd     = cpu_dout;
                m_pending = 1;
            end else if (rd_end) begin
                m_pending = 0;
            end
            if (ak_start) m_valid = 0;
            if (dn_start) begin
                m_reply = z80_dout;
                m_valid = 1;
            end
        end
        m_seen_clock = 1;
        {p_wr, p_rd, p_st, p_done, p_ack} = {wr, rd, st, dn, ak};
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_din;
        exp_din = a_rd() ? m_cmd : (a_st() ? {6'b0, m_overrun, m_pending} : 8'h00);
        check({tag, ".din"},   z80_din, exp_din);
        check({tag, ".oe"},    z80_din_oe, a_rd() || a_st());
        check({tag, ".int_n"}, z80_int_n, !m_pending);
        check({tag, ".reply"}, m68k_reply, m_reply);
        check({tag, ".valid"}, m68k_reply_valid, m_valid);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_model(tag);
    endtask

    task automatic idle_bus();
        sound_latch_w_cs = 0; cpu_rw = 1; sound_latch_r_cs = 0; sound_status_cs = 0;
        sound_done_cs = 0; z80_rd_n = 1; z80_wr_n = 1; m68k_reply_ack = 0;
    endtask

    initial begin
        idle_bus();
        cpu_dout = 8'h00; z80_dout = 8'h00;
        reset_n = 0;
        model_reset();
        #12;
        check("rst.int_n", z80_int_n, 1'b1);
        check("rst.din", z80_din, 8'h00);
        check("rst.oe", z80_din_oe, 1'b0);
        check("rst.reply", m68k_reply, 8'h00);
        check("rst.valid", m68k_reply_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1;
        repeat (2) step("prime");

        // Plain command round trip.
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h5a;
        step("t1.wr");
        check("t1.int_low", z80_int_n, 1'b0);
        sound_latch_w_cs = 0; cpu_rw = 1;
        step("t1.idle");
        sound_status_cs = 1; z80_rd_n = 0; #1;
        check("t1.status", z80_din, 8'h01);
        check("t1.status_oe", z80_din_oe, 1'b1);
        step("t1.st");
        z80_rd_n = 1; sound_status_cs = 0;
        step("t1.st_end");
        sound_latch_r_cs = 1; z80_rd_n = 0; #1;
        check("t1.cmd", z80_din, 8'h5a);
        step("t1.rd");
        check("t1.still_pend", z80_int_n, 1'b0);
        z80_rd_n = 1;
        step("t1.rd_end");
        check("t1.int_high", z80_int_n, 1'b1);
        sound_latch_r_cs = 0;
        step("t1.done");

        // Overrun: two writes, no read.
        foreach (cpu_dout[i]) begin end
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h11; step("t2.w1");
        sound_latch_w_cs = 0; cpu_rw = 1; step("t2.g1");
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h22; step("t2.w2");
        sound_latch_w_cs = 0; cpu_rw = 1; step("t2.g2");
        sound_status_cs = 1; z80_rd_n = 0; #1;
        check("t2.status", z80_din, 8'h03);
        step("t2.st");
        z80_rd_n = 1; sound_status_cs = 0; step("t2.st_end");
        sound_latch_r_cs = 1; z80_rd_n = 0; #1;
        check("t2.cmd", z80_din, 8'h22);
        step("t2.rd");
        z80_rd_n = 1; sound_latch_r_cs = 0; step("t2.rd_end");
        sound_status_cs = 1; z80_rd_n = 0; #1;
        check("t2.status_clr", z80_din, 8'h00);
        step("t2.st2");
        z80_rd_n = 1; sound_status_cs = 0; step("t2.st2_end");

        // Write coinciding with the end of a command read.
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h44; step("t3.w1");
        sound_latch_w_cs = 0; cpu_rw = 1; step("t3.g1");
        sound_latch_r_cs = 1; z80_rd_n = 0; step("t3.rd");
        z80_rd_n = 1; sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h33;
        step("t3.collide");
        check("t3.pend", z80_int_n, 1'b0);
        sound_latch_r_cs = 0; sound_latch_w_cs = 0; cpu_rw = 1; step("t3.g2");
        sound_status_cs = 1; z80_rd_n = 0; #1;
        check("t3.status", z80_din, 8'h01);
        step("t3.st");
        z80_rd_n = 1; sound_status_cs = 0; step("t3.st_end");
        sound_latch_r_cs = 1; z80_rd_n = 0; #1;
        check("t3.cmd", z80_din, 8'h33);
        step("t3.rd2");
        z80_rd_n = 1; sound_latch_r_cs = 0; step("t3.rd2_end");

        // Reply path, held strobe, ack, and write-vs-ack collision.
        sound_done_cs = 1; z80_wr_n = 0; z80_dout = 8'hc4;
        step("t4.wr");
        check("t4.reply", m68k_reply, 8'hc4);
        check("t4.valid", m68k_reply_valid, 1'b1);
        for (int i = 0; i < 10; i++) step("t4.hold");
        check("t4.valid_held", m68k_reply_valid, 1'b1);
        m68k_reply_ack = 1; step("t4.ack");
        check("t4.acked", m68k_reply_valid, 1'b0);
        sound_done_cs = 0; z80_wr_n = 1; m68k_reply_ack = 0; step("t4.g");
        sound_done_cs = 1; z80_wr_n = 0; z80_dout = 8'h5e; m68k_reply_ack = 1;
        step("t4.collide");
        check("t4.coll_valid", m68k_reply_valid, 1'b1);
        check("t4.coll_reply", m68k_reply, 8'h5e);
        idle_bus(); step("t4.end");

        // Latch select during a 68000 read does nothing.
        sound_latch_w_cs = 1; cpu_rw = 1; cpu_dout = 8'hff;
        repeat (3) step("t5.read");
        check("t5.int_n", z80_int_n, 1'b1);
        sound_latch_w_cs = 0; step("t5.end");

        // Reset in the middle of held write and read strobes.
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h77;
        sound_latch_r_cs = 1; z80_rd_n = 0;
        step("t6.busy");
        reset_n = 0; model_reset(); #1;
        check("t6.rst_int_n", z80_int_n, 1'b1);
        check("t6.rst_din", z80_din, 8'h00);
        check("t6.rst_valid", m68k_reply_valid, 1'b0);
        check("t6.rst_reply", m68k_reply, 8'h00);
        repeat (2) step("t6.in_rst");
        reset_n = 1;
        for (int i = 0; i < 5; i++) step("t6.held");
        check("t6.no_spurious", z80_int_n, 1'b1);
        sound_latch_w_cs = 0; cpu_rw = 1; sound_latch_r_cs = 0; z80_rd_n = 1;
        step("t6.drop");
        sound_latch_w_cs = 1; cpu_rw = 0; cpu_dout = 8'h99; step("t6.rewrite");
        check("t6.new_event", z80_int_n, 1'b0);
        idle_bus(); step("t6.end");

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) sound_latch_w_cs = ~sound_latch_w_cs;
            if ($urandom_range(7) == 0) cpu_rw = ~cpu_rw;
            if ($urandom_range(3) == 0) sound_latch_r_cs = ~sound_latch_r_cs;
            if ($urandom_range(3) == 0) sound_status_cs = ~sound_status_cs;
            if ($urandom_range(3) == 0) sound_done_cs = ~sound_done_cs;
            if ($urandom_range(2) == 0) z80_rd_n = ~z80_rd_n;
            if ($urandom_range(2) == 0) z80_wr_n = ~z80_wr_n;
            if ($urandom_range(4) == 0) m68k_reply_ack = ~m68k_reply_ack;
            cpu_dout = 8'($urandom);
            z80_dout = 8'($urandom);
            if ($urandom_range(249) == 0) begin
                reset_n = 0; model_reset(); #1;
                check_model("rnd.rst");
            end else if (!reset_n && $urandom_range(2) == 0) begin
                reset_n = 1;
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
